// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front-end
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int INST_BYTES = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer of {pc, inst} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  fetch_entry_t              wr_entry,
    output fetch_entry_t              head,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // pointers wrap naturally at DEPTH; flush empties without touching storage
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // entry storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC, request credits and redirect squashing around a prefetch queue
module ifetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = cnt_w(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc;
    logic [31:0]   target;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    fetch_entry_t  head;

    assign target         = redirect_pc & ~32'd3;
    assign imem_req_valid = !reset && !redirect && !full
                            && ({1'b0, in_flight} + {1'b0, count} < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !redirect && discard == '0;
    assign pop            = inst_valid && inst_ready;
    assign inst_valid     = !empty;
    assign inst           = head.inst;
    assign inst_pc        = head.pc;

    // fetch/tag PCs, outstanding-request credit and stale-response squash count
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            tag_pc    <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
        end else if (redirect) begin
            fetch_pc  <= target;
            tag_pc    <= target;
            in_flight <= in_flight - CW'(imem_rsp_valid);
            discard   <= in_flight - CW'(imem_rsp_valid);
        end else begin
            fetch_pc  <= accept ? fetch_pc + 32'(INST_BYTES) : fetch_pc;
            tag_pc    <= push ? tag_pc + 32'(INST_BYTES) : tag_pc;
            in_flight <= in_flight + CW'(accept) - CW'(imem_rsp_valid);
            discard   <= (imem_rsp_valid && discard != '0) ? discard - CW'(1) : discard;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .wr_entry ('{pc: tag_pc, inst: imem_rsp_data}),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: stream-level reference model, directed vectors and random traffic
module tb_ifetch_queue;

    logic        clk = 0;
    logic        reset = 1;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 0;
    logic [31:0] w_rsp_data = 0;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(1'b1), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .inst_valid(w_inst_valid), .inst(w_inst),
        .inst_pc(w_inst_pc), .inst_ready(1'b1)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] rpc; int lat; int pre; logic [31:0] exp_addr; } vec_t;

    mreq_t       mq[$];
    logic [31:0] w_reqs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] w_insts[$];
    vec_t        tbl[5];
    int          total = 0, bad = 0, cyc = 0, lat = 1, nacc = 0, npop = 0;
    logic [31:0] exp_req = 0, exp_pc = 0;
    logic        flush_prev = 0, rst_prev = 0, w_pend = 0;
    logic [31:0] w_pend_addr = 0;
    logic        arm_req = 0, arm_pop = 0;
    logic [31:0] fr_addr = 0, fp_pc = 0, fp_inst = 0;
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_addr, s_inst_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: drive memory responses, sample outputs mid-cycle, update the model
    task automatic cycle();
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = memf(mq[0].addr);
            void'(mq.pop_front());
        end
        w_rsp_valid = w_pend;
        w_rsp_data  = memf(w_pend_addr);
        #1;
        s_req_valid = imem_req_valid; s_addr = imem_req_addr;
        s_inst_valid = inst_valid; s_inst_pc = inst_pc;
        if (reset) begin
            chk("req_valid_in_reset", imem_req_valid, 0);
            mq.delete(); w_reqs.delete(); w_pcs.delete(); w_insts.delete();
            exp_req = 0; exp_pc = 0; nacc = 0;
            w_pend = 0;
        end else begin
            if (rst_prev) begin
                chk("inst_after_reset", inst, 0);
                chk("inst_pc_after_reset", inst_pc, 0);
            end
            if (flush_prev) chk("inst_valid_after_flush", inst_valid, 0);
            if (redirect) chk("req_valid_on_redirect", imem_req_valid, 0);
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                exp_req += 4; nacc++;
                if (arm_req) begin fr_addr = imem_req_addr; arm_req = 0; end
            end
            if (inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_data", inst, memf(exp_pc));
                exp_pc += 4; npop++;
                if (arm_pop) begin fp_pc = inst_pc; fp_inst = inst; arm_pop = 0; end
            end
            if (redirect) begin
                exp_req = redirect_pc & ~32'd3;
                exp_pc  = redirect_pc & ~32'd3;
                arm_req = 1; arm_pop = 1;
            end
            w_pend = w_req_valid; w_pend_addr = w_req_addr;
            if (w_req_valid && w_reqs.size() < 8) w_reqs.push_back(w_req_addr);
            if (w_inst_valid && w_pcs.size() < 8) begin
                w_pcs.push_back(w_inst_pc); w_insts.push_back(w_inst);
            end
        end
        flush_prev = reset || redirect;
        rst_prev   = reset;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1; redirect = 0;
        repeat (n) cycle();
        reset = 0;
    endtask

    task automatic wait_first();
        for (int i = 0; i < 40 && (arm_req || arm_pop); i++) cycle();
        chk("first_after_redirect_timeout", {31'b0, arm_req | arm_pop}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        tbl[0] = '{rpc: 32'h0000_0200, lat: 3, pre: 2, exp_addr: 32'h0000_0200};
        tbl[1] = '{rpc: 32'h0000_0102, lat: 1, pre: 2, exp_addr: 32'h0000_0100};
        tbl[2] = '{rpc: 32'hFFFF_FFFF, lat: 2, pre: 5, exp_addr: 32'hFFFF_FFFC};
        tbl[3] = '{rpc: 32'h8000_0007, lat: 1, pre: 0, exp_addr: 32'h8000_0004};
        tbl[4] = '{rpc: 32'h0000_0040, lat: 4, pre: 7, exp_addr: 32'h0000_0040};
        @(negedge clk);

        // reset release, k=1, consumer always ready
        lat = 1; inst_ready = 1; imem_req_ready = 1;
        do_reset(2);
        cycle();
        chk("first_req_valid", s_req_valid, 1);
        chk("first_req_addr", s_addr, 0);
        cycle();
        chk("inst_valid_before_latency", s_inst_valid, 0);
        cycle();
        chk("inst_valid_at_latency", s_inst_valid, 1);
        chk("first_inst_pc", s_inst_pc, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("throughput_valid", s_inst_valid, 1);
            chk("throughput_pc", s_inst_pc, 32'(4 * (i + 1)));
        end
        chk("wrap_req0", w_reqs[0], 32'hFFFF_FFF8);
        chk("wrap_req1", w_reqs[1], 32'hFFFF_FFFC);
        chk("wrap_req2", w_reqs[2], 32'h0000_0000);
        chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", w_pcs[2], 32'h0000_0000);
        chk("wrap_inst2", w_insts[2], memf(32'h0));

        // stalled consumer: credit caps outstanding work at DEPTH
        inst_ready = 0;
        do_reset(1);
        repeat (10) cycle();
        chk("stall_accepts", nacc, 4);
        chk("stall_req_valid", s_req_valid, 0);
        chk("stall_inst_valid", s_inst_valid, 1);
        chk("stall_inst_pc", s_inst_pc, 0);
        inst_ready = 1; arm_req = 1;
        for (int i = 0; i < 10 && arm_req; i++) cycle();
        chk("resume_req_addr", fr_addr, 32'h10);

        // redirect vectors
        foreach (tbl[i]) begin
            inst_ready = 1; imem_req_ready = 1; lat = tbl[i].lat;
            do_reset(1);
            repeat (tbl[i].pre) cycle();
            redirect = 1; redirect_pc = tbl[i].rpc;
            cycle();
            redirect = 0;
            wait_first();
            chk("vec_req_addr", fr_addr, tbl[i].exp_addr);
            chk("vec_inst_pc", fp_pc, tbl[i].exp_addr);
            chk("vec_inst", fp_inst, memf(tbl[i].exp_addr));
        end

        // back-to-back redirects discard cumulatively
        lat = 3; do_reset(1);
        repeat (3) cycle();
        redirect = 1; redirect_pc = 32'h300; cycle();
        redirect_pc = 32'h400; cycle();
        redirect = 0;
        wait_first();
        chk("b2b_inst_pc", fp_pc, 32'h400);
        chk("b2b_inst", fp_inst, memf(32'h400));

        // reset with queued entries and requests in flight
        inst_ready = 0; lat = 3; do_reset(1);
        repeat (5) cycle();
        reset = 1; cycle(); reset = 0;
        cycle();
        chk("midreset_inst_valid", s_inst_valid, 0);
        chk("midreset_req_valid", s_req_valid, 1);
        chk("midreset_req_addr", s_addr, 0);

        // random traffic against the stream model
        inst_ready = 1; do_reset(1);
        p0 = npop;
        for (int i = 0; i < 3000; i++) begin
            inst_ready     = $urandom_range(0, 3) != 0;
            imem_req_ready = $urandom_range(0, 3) != 0;
            lat            = $urandom_range(1, 4);
            redirect       = $urandom_range(0, 24) == 0;
            redirect_pc    = $urandom;
            reset          = $urandom_range(0, 999) == 0;
            cycle();
        end
        reset = 0; redirect = 0;
        chk("random_progress", {31'b0, (npop - p0) >= 300}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
